// File: rtl/quad_pkg.sv
// Shared quadrature definitions used by the step encoder and its matching decoder.
//   phase_t       2-bit Gray phase {qa,qb}
//   PH_*          named phase constants
//   state_t       encoder FSM states
//   next_phase()  one quadrature step in the requested direction
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  typedef enum logic {IDLE, RUN} state_t;

  // Up (dir=1): 00 -> 10 -> 11 -> 01 -> 00 (A leads B). Down walks it backwards.
  function automatic phase_t next_phase(input logic dir, input phase_t ph);
    phase_t nxt;
    nxt = PH_00;
    if (dir) begin
      case (ph)
        PH_00:   nxt = PH_10;
        PH_10:   nxt = PH_11;
        PH_11:   nxt = PH_01;
        default: nxt = PH_00;
      endcase
    end else begin
      case (ph)
        PH_00:   nxt = PH_01;
        PH_01:   nxt = PH_11;
        PH_11:   nxt = PH_10;
        default: nxt = PH_00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_encoder_step_timer.sv
// Step-period down-counter for the quadrature encoder.
//   clk, reset  clock / synchronous active-high reset
//   load        load counter with load_val (command accept)
//   run         count enable; on expiry reloads reload_val
//   load_val    value loaded on load
//   reload_val  value reloaded after each expiry
//   tick        counter is zero (a step is due when run is high)
module step_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] load_val,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= tick ? reload_val : cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/quad_step_encoder.sv
// Quadrature transmitter: converts move commands (direction + step count) into
// A/B quadrature at a step period of div+1 cycles, and keeps a shadow position.
//   clk, reset            clock / synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_dir               1 = up (A leads B), 0 = down
//   cmd_steps             number of quadrature steps
//   div                   step period minus one, captured at accept
//   pos_load, pos_data    overwrite the shadow position (wins over a step)
//   qa, qb                quadrature outputs
//   busy                  command running
//   done                  one-cycle pulse at completion
//   pos                   shadow position, wraps mod 2^CNT_W
module quad_step_encoder
  import quad_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] div,
  input  logic             pos_load,
  input  logic [CNT_W-1:0] pos_data,
  output logic             qa,
  output logic             qb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos
);

  state_t           state;
  logic             dir_q;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] div_q;
  phase_t           phase;

  logic accept;
  logic run_en;
  logic tick;
  logic step;

  assign accept = cmd_ready & cmd_valid;
  assign run_en = (state == RUN) && (remaining != '0);
  assign step   = run_en & tick;

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .run        (run_en),
    .load_val   (div),
    .reload_val (div_q),
    .tick       (tick)
  );

  // The final step leaves remaining at zero while still in RUN; the exit is
  // taken on the following cycle so done trails the last phase change by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      remaining <= '0;
      div_q     <= '0;
      phase     <= PH_00;
      pos       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q     <= cmd_dir;
            remaining <= cmd_steps;
            div_q     <= div;
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          if (step) begin
            phase     <= next_phase(dir_q, phase);
            remaining <= remaining - CNT_W'(1);
          end else if (remaining == '0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (pos_load) begin
        pos <= pos_data;
      end else if (step) begin
        pos <= dir_q ? pos + CNT_W'(1) : pos - CNT_W'(1);
      end
    end
  end

  assign qa = phase[1];
  assign qb = phase[0];

endmodule

// File: tb/tb_quad_step_encoder.sv
module tb_quad_step_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_steps = '0;
  logic [7:0] div = '0;
  logic       pos_load = 1'b0;
  logic [3:0] pos_data = '0;
  logic       qa, qb, busy, done;
  logic [3:0] pos;

  int unsigned checks = 0;
  int unsigned passed = 0;

  quad_step_encoder #(.CNT_W(4), .DIV_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .div       (div),
    .pos_load  (pos_load),
    .pos_data  (pos_data),
    .qa        (qa),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  // Reference decoder: counts quadrature edges, flags double toggles.
  logic [1:0] dec_prev = 2'b00;
  logic [3:0] dec_cnt = '0;
  int unsigned dec_viol = 0;

  always @(negedge clk) begin
    logic [1:0] cur;
    cur = {qa, qb};
    if (reset) begin
      dec_prev = 2'b00;
      dec_cnt  = '0;
    end else if (cur != dec_prev) begin
      if ((cur ^ dec_prev) == 2'b11) dec_viol++;
      else if ((dec_prev == 2'b00 && cur == 2'b10) || (dec_prev == 2'b10 && cur == 2'b11) ||
               (dec_prev == 2'b11 && cur == 2'b01) || (dec_prev == 2'b01 && cur == 2'b00))
        dec_cnt++;
      else
        dec_cnt--;
      dec_prev = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns in cycle T+1.
  task automatic issue(input logic d, input logic [3:0] s, input logic [7:0] dv);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = s; div = dv;
    tick();
    cmd_valid = 1'b0; cmd_dir = ~d; cmd_steps = 4'hF; div = 8'hFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({qa, qb, pos, cmd_ready, busy, done} !== {2'b00, 4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got qa/qb=%b%b pos=%0d rdy=%b busy=%b done=%b, want 00 0 1 0 0",
               qa, qb, pos, cmd_ready, busy, done);
    else passed++;
  endtask

  task automatic test_up_div0();
    logic [1:0] exp_ph [5];
    exp_ph = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
    issue(1'b1, 4'd5, 8'd0);
    checks++;
    if ({qa, qb, busy, cmd_ready} !== {2'b00, 1'b1, 1'b0})
      $display("FAIL up_accept: got qa/qb=%b%b busy=%b rdy=%b, want 00 1 0", qa, qb, busy, cmd_ready);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({qa, qb, pos, done} !== {exp_ph[k], 4'(k + 1), 1'b0})
        $display("FAIL up_step%0d: got qa/qb=%b%b pos=%0d done=%b, want %b %0d 0",
                 k, qa, qb, pos, done, exp_ph[k], k + 1);
      else passed++;
    end
    tick();
    checks++;
    if ({done, busy, cmd_ready, qa, qb} !== {1'b1, 1'b0, 1'b1, 2'b10})
      $display("FAIL up_done: got done=%b busy=%b rdy=%b qa/qb=%b%b, want 1 0 1 10",
               done, busy, cmd_ready, qa, qb);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b0) $display("FAIL up_done_width: got done=%b, want 0", done);
    else passed++;
    checks++;
    if (dec_cnt !== pos || dec_viol != 0)
      $display("FAIL up_decoder: got dec=%0d viol=%0d, want pos=%0d viol=0", dec_cnt, dec_viol, pos);
    else passed++;
  endtask

  // Down from pos=1, entered back-to-back on the done cycle of a 1-step up move.
  task automatic test_back_to_back_down();
    logic [1:0] exp_ph [3];
    logic [3:0] exp_pos [3];
    logic [1:0] ph_prev;
    logic [3:0] pos_prev;
    exp_ph  = '{2'b00, 2'b01, 2'b11};
    exp_pos = '{4'd0, 4'd15, 4'd14};
    reset = 1'b1; tick(); reset = 1'b0;
    issue(1'b1, 4'd1, 8'd0);
    tick();
    tick();
    checks++;
    if ({done, cmd_ready, qa, qb, pos} !== {1'b1, 1'b1, 2'b10, 4'd1})
      $display("FAIL b2b_pre: got done=%b rdy=%b qa/qb=%b%b pos=%0d, want 1 1 10 1",
               done, cmd_ready, qa, qb, pos);
    else passed++;
    issue(1'b0, 4'd3, 8'd3);
    checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    else passed++;
    ph_prev = 2'b10; pos_prev = 4'd1;
    for (int s = 0; s < 3; s++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        checks++;
        if (c < 4) begin
          if ({qa, qb, pos} !== {ph_prev, pos_prev})
            $display("FAIL down_hold%0d_%0d: got qa/qb=%b%b pos=%0d, want %b %0d",
                     s, c, qa, qb, pos, ph_prev, pos_prev);
          else passed++;
        end else begin
          if ({qa, qb, pos} !== {exp_ph[s], exp_pos[s]})
            $display("FAIL down_step%0d: got qa/qb=%b%b pos=%0d, want %b %0d",
                     s, qa, qb, pos, exp_ph[s], exp_pos[s]);
          else passed++;
        end
      end
      ph_prev = exp_ph[s]; pos_prev = exp_pos[s];
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b10) $display("FAIL down_done: got done=%b busy=%b, want 1 0", done, busy);
    else passed++;
    checks++;
    if (dec_cnt !== pos || dec_viol != 0)
      $display("FAIL down_decoder: got dec=%0d viol=%0d, want pos=%0d viol=0", dec_cnt, dec_viol, pos);
    else passed++;
  endtask

  task automatic test_zero_steps();
    tick();
    issue(1'b1, 4'd0, 8'd5);
    checks++;
    if ({done, cmd_ready, busy, qa, qb, pos} !== {1'b1, 1'b1, 1'b0, 2'b11, 4'd14})
      $display("FAIL zero_done: got done=%b rdy=%b busy=%b qa/qb=%b%b pos=%0d, want 1 1 0 11 14",
               done, cmd_ready, busy, qa, qb, pos);
    else passed++;
    tick(); tick();
    checks++;
    if ({done, qa, qb, pos} !== {1'b0, 2'b11, 4'd14})
      $display("FAIL zero_after: got done=%b qa/qb=%b%b pos=%0d, want 0 11 14", done, qa, qb, pos);
    else passed++;
  endtask

  task automatic test_pos_load();
    issue(1'b1, 4'd3, 8'd1);
    tick();
    pos_load = 1'b1; pos_data = 4'd9;
    tick();
    pos_load = 1'b0; pos_data = 4'd0;
    checks++;
    if ({qa, qb, pos} !== {2'b01, 4'd9})
      $display("FAIL load_step: got qa/qb=%b%b pos=%0d, want 01 9", qa, qb, pos);
    else passed++;
    tick(); tick();
    checks++;
    if ({qa, qb, pos} !== {2'b00, 4'd10})
      $display("FAIL load_next: got qa/qb=%b%b pos=%0d, want 00 10", qa, qb, pos);
    else passed++;
    tick(); tick();
    checks++;
    if ({qa, qb, pos, done} !== {2'b10, 4'd11, 1'b0})
      $display("FAIL load_last: got qa/qb=%b%b pos=%0d done=%b, want 10 11 0", qa, qb, pos, done);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL load_done: got done=%b, want 1", done);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int unsigned seen_done;
    reset = 1'b1; tick(); reset = 1'b0;
    issue(1'b1, 4'd8, 8'd0);
    tick(); tick(); tick();
    checks++;
    if ({qa, qb, pos, busy} !== {2'b01, 4'd3, 1'b1})
      $display("FAIL mid_pre: got qa/qb=%b%b pos=%0d busy=%b, want 01 3 1", qa, qb, pos, busy);
    else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if ({qa, qb, pos, busy, cmd_ready} !== {2'b00, 4'd0, 1'b0, 1'b1})
      $display("FAIL mid_reset: got qa/qb=%b%b pos=%0d busy=%b rdy=%b, want 00 0 0 1",
               qa, qb, pos, busy, cmd_ready);
    else passed++;
    tick();
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || qa || qb) seen_done++;
    end
    checks++;
    if (seen_done != 0) $display("FAIL mid_quiet: got %0d active cycles, want 0", seen_done);
    else passed++;
    issue(1'b1, 4'd2, 8'd0);
    tick();
    checks++;
    if ({qa, qb, pos} !== {2'b10, 4'd1})
      $display("FAIL mid_restart1: got qa/qb=%b%b pos=%0d, want 10 1", qa, qb, pos);
    else passed++;
    tick();
    checks++;
    if ({qa, qb, pos} !== {2'b11, 4'd2})
      $display("FAIL mid_restart2: got qa/qb=%b%b pos=%0d, want 11 2", qa, qb, pos);
    else passed++;
    tick();
    checks++;
    if (done !== 1'b1) $display("FAIL mid_done: got done=%b, want 1", done);
    else passed++;
    checks++;
    if (dec_cnt !== pos || dec_viol != 0)
      $display("FAIL mid_decoder: got dec=%0d viol=%0d, want pos=%0d viol=0", dec_cnt, dec_viol, pos);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_up_div0();
    test_back_to_back_down();
    test_zero_steps();
    test_pos_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
